// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle for serial_pattern_tx.
// The master offers words; the slave shifts them out.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [4:0]       in_len;
  logic             tx_bit;
  logic             tx_en;
  logic             done;

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, tx_bit, tx_en, done
  );

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, tx_bit, tx_en, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first serial word transmitter with a fixed idle-zero gap.
// Feeds single-bit stimulus streams into sequence detectors.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  serial_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam logic [4:0] WLEN = 5'(WIDTH);
  localparam logic [3:0] GAP_LD =
    (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP > 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       bit_cnt;
  logic [3:0]       gap_cnt;
  logic [4:0]       eff_len;
  logic [4:0]       shamt;

  always_comb begin
    eff_len = bus.in_len;
    if (bus.in_len == 5'd0 || bus.in_len > WLEN)
      eff_len = WLEN;
    shamt = WLEN - eff_len;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // left-align so the first bit sent sits at the MSB
            shreg   <= bus.in_data << shamt;
            bit_cnt <= 4'(eff_len - 5'd1);
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) begin
            if (HAS_GAP) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd0)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == S_IDLE) && !sys_rst;
  assign bus.tx_en    = (state == S_SHIFT);
  assign bus.tx_bit   = bus.tx_en & shreg[WIDTH-1];
  assign bus.done     = bus.tx_en && (bit_cnt == 4'd0);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: GAP=1 and GAP=0 instances
// checked cycle by cycle against a future-cycle queue model.
module tb_serial_pattern_tx;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b1;
  logic [7:0] data  = 8'h00;
  logic [4:0] len   = 5'd0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(8)) bus_a ();
  serial_pattern_tx_if #(.WIDTH(8)) bus_b ();

  assign bus_a.in_valid = valid;
  assign bus_a.in_data  = data;
  assign bus_a.in_len   = len;
  assign bus_b.in_valid = valid;
  assign bus_b.in_data  = data;
  assign bus_b.in_len   = len;

  serial_pattern_tx #(.WIDTH(8), .GAP(1)) dut_a (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_a)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_b)
  );

  typedef struct packed {
    logic en;
    logic b;
    logic dn;
    logic rdy;
  } ent_t;

  localparam ent_t IDLE_E = 4'b0001;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic chk_i(input string nm, input int act,
                       input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference: on a handshake the whole future of the word
  // (payload cycles then gap cycles) is queued up front.
  ent_t       mq[2][$];
  ent_t       cur[2] = '{IDLE_E, IDLE_E};
  int         gapv[2] = '{1, 0};
  int         ml;
  logic [7:0] md;
  ent_t       me;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mq[d].delete();
        cur[d] = IDLE_E;
      end else begin
        if (cur[d].rdy && valid) begin
          ml = (len == 5'd0 || len > 5'd8) ? 8 : int'(len);
          md = data;
          for (int i = ml - 1; i >= 0; i--) begin
            me.en = 1'b1; me.b = md[i];
            me.dn = (i == 0); me.rdy = 1'b0;
            mq[d].push_back(me);
          end
          for (int g = 0; g < gapv[d]; g++)
            mq[d].push_back(4'b0000);
        end
        if (mq[d].size() > 0) cur[d] = mq[d].pop_front();
        else cur[d] = IDLE_E;
      end
    end
    #1;
    chk("tx_en_a",    bus_a.tx_en,    cur[0].en);
    chk("tx_bit_a",   bus_a.tx_bit,   cur[0].b);
    chk("done_a",     bus_a.done,     cur[0].dn);
    chk("in_ready_a", bus_a.in_ready, cur[0].rdy && !rst);
    chk("tx_en_b",    bus_b.tx_en,    cur[1].en);
    chk("tx_bit_b",   bus_b.tx_bit,   cur[1].b);
    chk("done_b",     bus_b.done,     cur[1].dn);
    chk("in_ready_b", bus_b.in_ready, cur[1].rdy && !rst);
  end

  int hs_a = 0;
  int hs_b = 0;
  always @(posedge clk) begin
    if (valid && bus_a.in_ready) hs_a++;
    if (valid && bus_b.in_ready) hs_b++;
  end

  logic rec = 1'b0;
  ent_t rec_a[$];
  ent_t rec_b[$];
  always @(posedge clk) begin
    #1;
    if (rec) begin
      rec_a.push_back({bus_a.tx_en, bus_a.tx_bit,
                       bus_a.done, bus_a.in_ready});
      rec_b.push_back({bus_b.tx_en, bus_b.tx_bit,
                       bus_b.done, bus_b.in_ready});
    end
  end

  task automatic send(input logic [7:0] d,
                      input logic [4:0] l);
    bit ok;
    ok = 0;
    @(negedge clk);
    data = d; len = l; valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (bus_a.in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    valid = 1'b0;
    if (!ok) chk_i("send_timeout", 0, 1);
  endtask

  task automatic analyze_a(output int n, output int bits,
                           output int ndone,
                           output int last_done,
                           output int first,
                           output int rdy_at);
    n = 0; bits = 0; ndone = 0; last_done = 0;
    first = -1; rdy_at = -1;
    for (int j = 0; j < rec_a.size(); j++) begin
      if (rec_a[j].en) begin
        if (first < 0) first = j;
        bits = (bits << 1) | int'(rec_a[j].b);
        n++;
        last_done = int'(rec_a[j].dn);
      end
      if (rec_a[j].dn) ndone++;
      if (first >= 0 && rdy_at < 0 && rec_a[j].rdy)
        rdy_at = j;
    end
  endtask

  task automatic capture_word(input logic [7:0] d,
                              input logic [4:0] l,
                              output int n, output int bits,
                              output int ndone,
                              output int last_done,
                              output int first,
                              output int rdy_at);
    rec_a.delete();
    rec_b.delete();
    rec = 1'b1;
    send(d, l);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rec = 1'b0;
    analyze_a(n, bits, ndone, last_done, first, rdy_at);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [4:0] l;
    int         n;
    int         bits;
  } vec_t;

  vec_t vec[8];

  int n, bits, ndone, ldone, first, rdy_at;
  int h0;
  int fb;
  logic [1:0] exp_en6 [6];

  initial begin
    vec[0] = '{8'h05, 5'd3,  3, 'h5};
    vec[1] = '{8'hA5, 5'd0,  8, 'hA5};
    vec[2] = '{8'hA5, 5'd20, 8, 'hA5};
    vec[3] = '{8'h0D, 5'd4,  4, 'hD};
    vec[4] = '{8'h15, 5'd5,  5, 'h15};
    vec[5] = '{8'h80, 5'd8,  8, 'h80};
    vec[6] = '{8'hFF, 5'd9,  8, 'hFF};
    vec[7] = '{8'h02, 5'd2,  2, 'h2};

    // reset held with valid high
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_tx_en",    bus_a.tx_en,    1'b0);
      chk("rst_tx_bit",   bus_a.tx_bit,   1'b0);
      chk("rst_done",     bus_a.done,     1'b0);
      chk("rst_in_ready", bus_a.in_ready, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_ready_a", bus_a.in_ready, 1'b1);
    chk("post_rst_ready_b", bus_b.in_ready, 1'b1);
    chk_i("rst_no_hs", hs_a, 0);

    for (int t = 0; t < 8; t++) begin
      capture_word(vec[t].d, vec[t].l,
                   n, bits, ndone, ldone, first, rdy_at);
      chk_i($sformatf("vec%0d_len", t), n, vec[t].n);
      chk_i($sformatf("vec%0d_bits", t), bits, vec[t].bits);
      chk_i($sformatf("vec%0d_done_cnt", t), ndone, 1);
      chk_i($sformatf("vec%0d_done_last", t), ldone, 1);
      chk_i($sformatf("vec%0d_ready_at", t), rdy_at,
            first + vec[t].n + 1);
    end

    // back-to-back on the GAP=0 instance
    rec_a.delete(); rec_b.delete();
    h0 = hs_b;
    rec = 1'b1;
    @(negedge clk);
    data = 8'h03; len = 5'd2; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hs_b > h0) break;
    end
    data = 8'h02; len = 5'd3;
    for (int k = 0; k < 20; k++) begin
      if (hs_b > h0 + 1) break;
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rec = 1'b0;
    chk_i("b2b_handshakes", hs_b - h0, 2);
    exp_en6 = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b10};
    fb = -1;
    for (int j = 0; j < rec_b.size(); j++)
      if (fb < 0 && rec_b[j].en) fb = j;
    if (fb < 0 || fb + 6 > rec_b.size()) begin
      chk_i("b2b_stream_len", rec_b.size(), fb + 6);
    end else begin
      for (int j = 0; j < 6; j++) begin
        chk_i($sformatf("b2b_en%0d", j),
              int'(rec_b[fb+j].en), int'(exp_en6[j][1]));
        chk_i($sformatf("b2b_bit%0d", j),
              int'(rec_b[fb+j].b), int'(exp_en6[j][0]));
        chk_i($sformatf("b2b_ready%0d", j),
              int'(rec_b[fb+j].rdy), (j == 2) ? 1 : 0);
      end
    end

    // inputs change while shifting
    rec_a.delete(); rec_b.delete();
    rec = 1'b1;
    send(8'h0D, 5'd4);
    data = 8'hFF; len = 5'd8;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rec = 1'b0;
    analyze_a(n, bits, ndone, ldone, first, rdy_at);
    chk_i("midchg_len",  n,    4);
    chk_i("midchg_bits", bits, 'hD);
    chk_i("midchg_done", ndone, 1);

    // reset after the third payload bit
    rec_a.delete(); rec_b.delete();
    rec = 1'b1;
    send(8'hFF, 5'd8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_tx_en_a", bus_a.tx_en, 1'b0);
    chk("abort_done_a",  bus_a.done,  1'b0);
    chk("abort_tx_en_b", bus_b.tx_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rec = 1'b0;
    analyze_a(n, bits, ndone, ldone, first, rdy_at);
    chk_i("abort_len",  n,     3);
    chk_i("abort_bits", bits,  'h7);
    chk_i("abort_done", ndone, 0);

    capture_word(8'h05, 5'd3,
                 n, bits, ndone, ldone, first, rdy_at);
    chk_i("after_abort_len",  n,    3);
    chk_i("after_abort_bits", bits, 'h5);
    chk_i("after_abort_done", ldone, 1);

    // random traffic, checked by the reference queue
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      valid = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      len   = 5'($urandom_range(0, 20));
      rst   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
